// File: rtl/fpu_op_scheduler.sv
// Single-operation FPU sequencer: latch request, consult exception handler, run datapath or return special result.
// Optional statistics counters are enabled by defining FPU_SCHED_STATS_EN.
module fpu_op_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_CNT_W       = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_num1,
    input  logic [DATA_WIDTH-1:0] req_num2,
    input  logic [OP_WIDTH-1:0]   req_opcode,
    output logic [DATA_WIDTH-1:0] exc_num1,
    output logic [DATA_WIDTH-1:0] exc_num2,
    output logic [OP_WIDTH-1:0]   exc_opcode,
    input  logic                  exc_sel,
    input  logic [DATA_WIDTH-1:0] exc_out,
    output logic                  dp_start,
    input  logic                  dp_done,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  res_exc,
    output logic                  res_timeout
`ifdef FPU_SCHED_STATS_EN
   ,output logic [31:0]           stat_ops,
    output logic [15:0]           stat_exc,
    output logic [15:0]           stat_to
`endif
);

    localparam logic [DATA_WIDTH-1:0] QNAN    = DATA_WIDTH'(32'h7FC0_0000);
    localparam logic [TO_CNT_W-1:0]   TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  dp_start_q;
    logic                  res_valid_q;
    logic                  res_exc_q;
    logic                  res_to_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] num1_q;
    logic [DATA_WIDTH-1:0] num2_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [TO_CNT_W-1:0]   cnt_q;

    // Held low during reset so nothing is accepted until the block is live.
    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign dp_start    = dp_start_q;
    assign res_valid   = res_valid_q;
    assign res_exc     = res_exc_q;
    assign res_timeout = res_to_q;
    assign result      = result_q;
    assign exc_num1    = num1_q;
    assign exc_num2    = num2_q;
    assign exc_opcode  = op_q;

    // Operation sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dp_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_exc_q   <= 1'b0;
            res_to_q    <= 1'b0;
            result_q    <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
        end else begin
            dp_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        num1_q  <= req_num1;
                        num2_q  <= req_num2;
                        op_q    <= req_opcode;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!exc_sel) begin
                        result_q    <= exc_out;
                        res_exc_q   <= 1'b1;
                        res_to_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        dp_start_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q + TO_CNT_W'(1);
                    // A completion in the final allowed cycle still beats the abort.
                    if (dp_done) begin
                        result_q    <= dp_result;
                        res_exc_q   <= 1'b0;
                        res_to_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        result_q    <= QNAN;
                        res_exc_q   <= 1'b0;
                        res_to_q    <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_exc_q, stat_exc_d;
    logic [15:0] stat_to_q,  stat_to_d;
    logic        resp_fire_s;

    assign resp_fire_s = (state_q == S_RESP) && res_ready;
    assign stat_ops    = stat_ops_q;
    assign stat_exc    = stat_exc_q;
    assign stat_to     = stat_to_q;

    // Saturating completion counters.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_exc_d = stat_exc_q;
        stat_to_d  = stat_to_q;
        if (resp_fire_s) begin
            if (stat_ops_q != 32'hFFFF_FFFF) stat_ops_d = stat_ops_q + 32'd1;
            else                             stat_ops_d = stat_ops_q;
            if (res_exc_q && (stat_exc_q != 16'hFFFF)) stat_exc_d = stat_exc_q + 16'd1;
            else                                       stat_exc_d = stat_exc_q;
            if (res_to_q && (stat_to_q != 16'hFFFF)) stat_to_d = stat_to_q + 16'd1;
            else                                     stat_to_d = stat_to_q;
        end else begin
            stat_ops_d = stat_ops_q;
            stat_exc_d = stat_exc_q;
            stat_to_d  = stat_to_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= 32'd0;
            stat_exc_q <= 16'd0;
            stat_to_q  <= 16'd0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_exc_q <= stat_exc_d;
            stat_to_q  <= stat_to_d;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: directed requests, a latency/age-based reference model and a per-cycle compare.
module tb_fpu_op_scheduler;
    localparam int T    = 8;
    localparam int TMAX = 60;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_num1 = 32'd0, req_num2 = 32'd0;
    logic [1:0]  req_opcode = 2'd0;
    logic [31:0] exc_num1, exc_num2;
    logic [1:0]  exc_opcode;
    logic        exc_sel = 1'b0;
    logic [31:0] exc_out = 32'd0;
    logic        dp_start;
    logic        dp_done = 1'b0;
    logic [31:0] dp_result = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] result;
    logic        res_exc, res_timeout;
`ifdef FPU_SCHED_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_exc, stat_to;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_op_scheduler #(
        .DATA_WIDTH(32), .OP_WIDTH(2), .TIMEOUT_CYCLES(T), .TO_CNT_W(7)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num1(req_num1), .req_num2(req_num2), .req_opcode(req_opcode),
        .exc_num1(exc_num1), .exc_num2(exc_num2), .exc_opcode(exc_opcode),
        .exc_sel(exc_sel), .exc_out(exc_out),
        .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_exc(res_exc), .res_timeout(res_timeout)
`ifdef FPU_SCHED_STATS_EN
       ,.stat_ops(stat_ops), .stat_exc(stat_exc), .stat_to(stat_to)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each operation is tracked by its age in cycles since the accept edge.
    int          cyc = 0;
    logic        m_busy = 1'b0, m_resp = 1'b0, m_start = 1'b0;
    int          m_acc = 0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
    logic [1:0]  m_op = 2'd0;
    logic        m_exc = 1'b0, m_to = 1'b0;
    int          s_ops = 0, s_exc = 0, s_to = 0;
    logic        m_idle;
    int          m_age;

    assign m_idle = !m_busy && !m_resp;
    assign m_age  = cyc - m_acc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_start <= 1'b0;
            m_a <= 32'd0; m_b <= 32'd0; m_op <= 2'd0;
            m_res <= 32'd0; m_exc <= 1'b0; m_to <= 1'b0;
            s_ops <= 0; s_exc <= 0; s_to <= 0;
        end else begin
            m_start <= 1'b0;
            if (m_resp && res_ready) begin
                m_resp <= 1'b0;
                s_ops  <= s_ops + 1;
                s_exc  <= s_exc + (m_exc ? 1 : 0);
                s_to   <= s_to + (m_to ? 1 : 0);
            end else if (m_busy) begin
                if (m_age == 1) begin
                    if (!exc_sel) begin
                        m_busy <= 1'b0; m_resp <= 1'b1;
                        m_res <= exc_out; m_exc <= 1'b1; m_to <= 1'b0;
                    end else begin
                        m_start <= 1'b1;
                    end
                end else if (dp_done) begin
                    m_busy <= 1'b0; m_resp <= 1'b1;
                    m_res <= dp_result; m_exc <= 1'b0; m_to <= 1'b0;
                end else if (m_age == T + 1) begin
                    m_busy <= 1'b0; m_resp <= 1'b1;
                    m_res <= QNAN; m_exc <= 1'b0; m_to <= 1'b1;
                end
            end
            if (m_idle && req_valid) begin
                m_busy <= 1'b1; m_acc <= cyc;
                m_a <= req_num1; m_b <= req_num2; m_op <= req_opcode;
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_dp_start", 32'(dp_start), 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_flags", {30'd0, res_exc, res_timeout}, 32'd0);
            chk("rst_exc_num1", exc_num1, 32'd0);
            chk("rst_exc_num2", exc_num2, 32'd0);
            chk("rst_exc_opcode", 32'(exc_opcode), 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(m_idle));
            chk("res_valid", 32'(res_valid), 32'(m_resp));
            chk("dp_start", 32'(dp_start), 32'(m_start));
            chk("exc_num1", exc_num1, m_a);
            chk("exc_num2", exc_num2, m_b);
            chk("exc_opcode", 32'(exc_opcode), 32'(m_op));
            if (m_resp) begin
                chk("result", result, m_res);
                chk("res_exc", 32'(res_exc), 32'(m_exc));
                chk("res_timeout", 32'(res_timeout), 32'(m_to));
            end
`ifdef FPU_SCHED_STATS_EN
            chk("stat_ops", stat_ops, 32'(s_ops));
            chk("stat_exc", 32'(stat_exc), 32'(s_exc));
            chk("stat_to", 32'(stat_to), 32'(s_to));
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request; dp_at is the cycle after accept at which dp_done is raised (-1 = never).
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input int dp_at, input logic [31:0] dpv,
                           input int exp_lat, input int exp_starts, input logic [31:0] exp_res,
                           input logic exp_exc, input logic exp_to, input bit do_hs);
        int k, lat, starts;
        req_num1 = a; req_num2 = b; req_opcode = op; req_valid = 1'b1;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        k = 0; lat = 0; starts = 0;
        while (lat == 0 && k < TMAX) begin
            if (k == dp_at) begin
                dp_done = 1'b1; dp_result = dpv;
            end else begin
                dp_done = 1'b0;
            end
            tick;
            k++;
            if (dp_start) starts++;
            if (res_valid) lat = k + 1;
        end
        dp_done = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_dp_starts"}, 32'(starts), 32'(exp_starts));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_res_exc"}, 32'(res_exc), 32'(exp_exc));
        chk({tag, "_res_timeout"}, 32'(res_timeout), 32'(exp_to));
        if (do_hs) begin
            res_ready = 1'b1;
            tick;
            res_ready = 1'b0;
            chk({tag, "_released"}, 32'(res_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        tick;
        chk("release_req_ready", 32'(req_ready), 32'd1);

        // Exception path: inf + -inf, handler returns qNaN.
        exc_sel = 1'b0; exc_out = QNAN;
        run_req("exc", 32'h7F80_0000, 32'hFF80_0000, 2'b00, -1, 32'd0,
                2, 0, QNAN, 1'b1, 1'b0, 1'b1);
        chk("exc_num1_held", exc_num1, 32'h7F80_0000);

        // Normal path: 2.0 * 3.0 = 6.0, done three cycles after dp_start.
        exc_sel = 1'b1;
        run_req("mul", 32'h4000_0000, 32'h4040_0000, 2'b10, 4, 32'h40C0_0000,
                6, 1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1);

        // Timeout: datapath never completes.
        dp_result = 32'hDEAD_BEEF;
        run_req("timeout", 32'h3F80_0000, 32'h0000_0000, 2'b11, -1, 32'd0,
                T + 2, 1, QNAN, 1'b0, 1'b1, 1'b1);
`ifdef FPU_SCHED_STATS_EN
        chk("stats_ops3", stat_ops, 32'd3);
        chk("stats_exc1", 32'(stat_exc), 32'd1);
        chk("stats_to1", 32'(stat_to), 32'd1);
`endif

        // Backpressure with a pending request.
        exc_sel = 1'b0; exc_out = 32'h1234_5678;
        run_req("bp", 32'h3F80_0000, 32'h3F80_0000, 2'b01, -1, 32'd0,
                2, 0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        req_num1 = 32'hAAAA_0001; req_num2 = 32'h5555_0002; req_opcode = 2'b10;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_result_stable", result, 32'h1234_5678);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("bp_bubble_num1", exc_num1, 32'h3F80_0000);
        chk("bp_bubble_ready", 32'(req_ready), 32'd1);
        tick;
        req_valid = 1'b0;
        chk("bp_accept_num1", exc_num1, 32'hAAAA_0001);
        chk("bp_accept_ready", 32'(req_ready), 32'd0);
        tick;
        chk("bp2_res_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;

        // Reset during EXEC, then a stray completion.
        exc_sel = 1'b1;
        req_num1 = 32'h4100_0000; req_num2 = 32'h4000_0000; req_opcode = 2'b11;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
        dp_done = 1'b1; dp_result = 32'h5555_5555;
        tick;
        dp_done = 1'b0;
        repeat (2) tick;
        chk("rstx_res_valid", 32'(res_valid), 32'd0);
        chk("rstx_req_ready", 32'(req_ready), 32'd1);
        chk("rstx_result", result, 32'd0);
        chk("rstx_exc_num1", exc_num1, 32'd0);
        chk("rstx_dp_start", 32'(dp_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Sequences one floating-point operation at a time through the FPU: latches operands/opcode from a requester and presents them to the exception handler.
- If the handler flags an exception, the handler's result is returned directly. Otherwise the operation is dispatched to the arithmetic datapath and the block waits for completion.
- Sits between the FPU top-level request interface and the exception-handler/arithmetic-unit pair. A timeout guards against a hung datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 2, opcode width (00 add, 01 sub, 10 mul, 11 div)
- TIMEOUT_CYCLES, 64, max EXEC cycles before forced abort (must be ≥2)
- TO_CNT_W, 7, timeout counter width (≥ clog2(TIMEOUT_CYCLES)+1)

Ports:
- clk  in  1  clock; all state rising-edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_num1  in  DATA_WIDTH  operand A
- req_num2  in  DATA_WIDTH  operand B
- req_opcode  in  OP_WIDTH  operation
- exc_num1  out  DATA_WIDTH  latched operand A to exception handler and datapath
- exc_num2  out  DATA_WIDTH  latched operand B to exception handler and datapath
- exc_opcode  out  OP_WIDTH  latched opcode to exception handler and datapath
- exc_sel  in  1  from handler: 1 = normal operation, 0 = exception case
- exc_out  in  DATA_WIDTH  handler special-case result
- dp_start  out  1  one-cycle datapath start pulse
- dp_done  in  1  datapath completion pulse
- dp_result  in  DATA_WIDTH  datapath result, valid with dp_done
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  returned value
- res_exc  out  1  result came from exception path
- res_timeout  out  1  result is timeout abort

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=0 while rst asserted, 1 on first cycle after release. dp_start=0, res_valid=0, result=0, res_exc=0, res_timeout=0, exc_num1/2=0, exc_opcode=0, timeout counter=0. Reset mid-operation abandons the op; later dp_done is ignored.
- States: IDLE, CHECK, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_num1/num2/opcode into exc_num1/num2/opcode and go to CHECK.
  - req_ready=0 in every other state.
- CHECK (exactly 1 cycle; handler is combinational on latched operands):
  - exc_sel=0: result<=exc_out, res_exc<=1, res_timeout<=0, go to RESP.
  - exc_sel=1: dp_start<=1 for exactly one cycle, counter<=0, go to EXEC.
- EXEC:
  - Counter increments each cycle.
  - dp_done=1: result<=dp_result, res_exc<=0, res_timeout<=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: result<=32'h7FC00000 (qNaN), res_timeout<=1, res_exc<=0, go to RESP.
  - dp_done and timeout in the same cycle: dp_done wins.
- RESP:
  - res_valid=1; result/res_exc/res_timeout stable until handshake.
  - res_valid&&res_ready: go to IDLE, res_valid<=0.
  - No new request accepted in the same cycle (one bubble).
- Latency (accept edge = cycle 0): exception path res_valid at cycle 2; normal path res_valid 1 cycle after the dp_done cycle; timeout at cycle TIMEOUT_CYCLES+2.
- dp_done outside EXEC is ignored. exc_num*/exc_opcode hold until the next accepted request.
- Invalid or unused opcodes are passed through unchanged; the handler decides exc_sel.

Optional Feature:
- Macro FPU_SCHED_STATS_EN.
- When defined:
  - Adds outputs stat_ops (32-bit), stat_exc (16-bit), stat_to (16-bit).
  - stat_ops increments on each completed RESP handshake.
  - stat_exc increments on each completed RESP handshake with res_exc=1.
  - stat_to increments on each completed RESP handshake with res_timeout=1.
  - All counters saturate at max, reset to 0, and are readable at any time.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Exception path: reset; req add num1=7F800000 num2=FF800000, exc_sel=0, exc_out=7FC00000 → res_valid at cycle 2, result=7FC00000, res_exc=1, dp_start never pulses.
- Normal path: mul 40000000×40400000, exc_sel=1; datapath returns dp_done 3 cycles after dp_start with 40C00000 → dp_start single pulse in cycle after CHECK; result=40C00000, res_exc=0, res_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, dp_done never asserted → res_valid at cycle 10, result=7FC00000, res_timeout=1.
- Backpressure: hold res_ready=0 for 5 cycles in RESP with a new req_valid pending → result stable, req_ready=0; request accepted only in IDLE after res_ready.
- Reset mid-EXEC: assert rst during EXEC, then release; stray dp_done afterwards → all outputs at reset values, no res_valid, req_ready=1.
- Stats (with macro): 3 ops (1 exception, 1 timeout, 1 normal) → stat_ops=3, stat_exc=1, stat_to=1.
